// File: rtl/fpga_robots_game_serial_rx_pkg.sv
// Shared constants for the serial receiver: receiver state encodings and the
// depth of the optional receive FIFO.
package fpga_robots_game_serial_rx_pkg;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  localparam int RX_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = RX_IDLE,
    ST_START = RX_START,
    ST_DATA  = RX_DATA,
    ST_STOP  = RX_STOP,
    ST_BREAK = RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/fpga_robots_game_serial_rx_if.sv
// Byte hand-off bundle between the serial receiver and game logic.
//   rx_data      : oldest received byte, meaningful while rx_valid is high
//   rx_valid     : a byte is available
//   rx_ack       : consumer pops rx_data (ignored while rx_valid is low)
//   rx_overrun   : one-cycle pulse, completed byte dropped (storage full)
//   rx_frame_err : one-cycle pulse, stop bit sampled low
// master = receiver side, slave = consumer side.
interface fpga_robots_game_serial_rx_if;
  import fpga_robots_game_serial_rx_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;

  modport master (output rx_data, output rx_valid, output rx_overrun,
                  output rx_frame_err, input rx_ack);
  modport slave  (input rx_data, input rx_valid, input rx_overrun,
                  input rx_frame_err, output rx_ack);

endinterface

// File: rtl/fpga_robots_game_rx_fifo.sv
// Parameterised-depth receive FIFO with push/pop and full/empty status.
//   push_i/data_i : write a byte (dropped, with overrun_o pulse, when full
//                   unless a pop happens in the same cycle)
//   pop_i         : remove the head entry (ignored when empty)
//   data_o        : head entry
//   full_o/empty_o: occupancy status
//   overrun_o     : registered one-cycle pulse on a dropped push
// Depth 1 behaves exactly like a single holding register.
module fpga_robots_game_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overrun_o
);
  import fpga_robots_game_serial_rx_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovr_q;
  logic             pop_ok_s, push_ok_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // A pop in the same cycle frees a slot, so a push to a full FIFO succeeds.
  assign pop_ok_s  = pop_i && (cnt_q != {CNT_W{1'b0}});
  assign push_ok_s = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok_s);

  // Storage, pointers, occupancy and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= push_i && !push_ok_s;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_ok_s) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o    = mem_q[rd_ptr_q];
  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign overrun_o = ovr_q;

endmodule

// File: rtl/fpga_robots_game_serial_rx.sv
// 8N1 UART receiver sampling at 8x oversampling on the baud8 strobe.
// Rebuilds bytes LSB first and hands them to game logic over rx_if.
//   clk, rst_n : system clock, asynchronous active-low reset
//   baud8      : single-cycle pulse at 8x the bit rate
//   rxd        : asynchronous serial input, idle high
//   rx_if      : byte hand-off (master side), see the interface file
// Build option FPGA_ROBOTS_RX_FIFO_EN: when defined, received bytes are held
// in a 4-entry FIFO; otherwise a single holding register is used.
module fpga_robots_game_serial_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] MID_TICK    = 3'd3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baud8,
  input  logic rxd,
  fpga_robots_game_serial_rx_if.master rx_if
);
  import fpga_robots_game_serial_rx_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  rx_state_e              state_q;
  logic [2:0]             tick_q;
  logic [2:0]             bitn_q;
  logic [7:0]             shift_q;
  logic                   frame_err_q;
  logic                   push_s;

  // Synchroniser for the asynchronous serial line; resets to idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{1'b1}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // A good stop bit delivers the completed byte to storage this cycle.
  assign push_s = baud8 && (state_q == ST_STOP) && (tick_q == 3'd7) && rxd_s;

  // Receive state machine; advances only on baud8 strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= 3'd0;
      bitn_q      <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (baud8) begin
        case (state_q)
          ST_IDLE: begin
            if (!rxd_s) begin
              state_q <= ST_START;
              tick_q  <= 3'd0;
            end
          end
          ST_START: begin
            // Mid-point of the start bit: a high line here was only a glitch.
            if (tick_q == MID_TICK) begin
              state_q <= rxd_s ? ST_IDLE : ST_DATA;
              tick_q  <= 3'd0;
              bitn_q  <= 3'd0;
            end else begin
              tick_q <= tick_q + 3'd1;
            end
          end
          ST_DATA: begin
            // Every 8th strobe after the previous sample is mid-bit.
            if (tick_q == 3'd7) begin
              shift_q <= {rxd_s, shift_q[7:1]};
              tick_q  <= 3'd0;
              if (bitn_q == 3'd7) state_q <= ST_STOP;
              else                bitn_q  <= bitn_q + 3'd1;
            end else begin
              tick_q <= tick_q + 3'd1;
            end
          end
          ST_STOP: begin
            if (tick_q == 3'd7) begin
              tick_q <= 3'd0;
              if (rxd_s) begin
                state_q <= ST_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_BREAK;
              end
            end else begin
              tick_q <= tick_q + 3'd1;
            end
          end
          ST_BREAK: begin
            // Hold off until the line returns high so a stuck-low line
            // cannot produce a stream of bytes.
            if (rxd_s) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_if.rx_frame_err = frame_err_q;

`ifdef FPGA_ROBOTS_RX_FIFO_EN
  logic fifo_empty_s;
  logic fifo_full_s;

  fpga_robots_game_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_s),
    .data_i    (shift_q),
    .pop_i     (rx_if.rx_ack),
    .data_o    (rx_if.rx_data),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .overrun_o (rx_if.rx_overrun)
  );

  assign rx_if.rx_valid = !fifo_empty_s;
`else
  logic [7:0] data_q;
  logic       valid_q;
  logic       ovr_q;

  // Single holding register; an ack in the push cycle makes room for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (push_s) begin
        if (!valid_q || rx_if.rx_ack) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (rx_if.rx_ack) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_fpga_robots_game_serial_rx.sv
// Bench for the serial receiver. Frames are driven on rxd with baud8 pulsing
// every 4 clocks (32 clocks per bit). From each frame's launch cycle the bench
// works out on which clock the stop bit is judged, and a queue-based model of
// the byte storage predicts rx_valid/rx_data/rx_overrun/rx_frame_err for every
// clock; a negedge process compares the DUT with that model.
module tb_fpga_robots_game_serial_rx;

`ifdef FPGA_ROBOTS_RX_FIFO_EN
  localparam int MDEPTH = 4;
`else
  localparam int MDEPTH = 1;
`endif

  logic clk;
  logic rst_n;
  logic baud8;
  logic rxd;

  fpga_robots_game_serial_rx_if rx_if ();

  fpga_robots_game_serial_rx #(
    .SYNC_STAGES (2),
    .MID_TICK    (3'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .baud8 (baud8),
    .rxd   (rxd),
    .rx_if (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         ack_mode = 0;
  int         ack_edge = -1;
  bit         ack_next_push = 1'b0;
  bit         chk_en = 1'b0;
  int         ovr_cnt = 0;
  int         ferr_cnt = 0;

  logic [7:0] push_at [int];
  bit         ferr_at [int];
  logic [7:0] mq [$];
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ovr = 1'b0;
  logic       exp_ferr = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one clock, update the storage model for that edge, set next inputs.
  task automatic step();
    bit pu;
    bit pop;
    @(posedge clk);
    cyc++;
    #1;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    if (rst_n) begin
      pu       = push_at.exists(cyc);
      exp_ferr = ferr_at.exists(cyc);
      pop      = (rx_if.rx_ack === 1'b1) && (mq.size() > 0);
      if (pu && mq.size() == MDEPTH && !pop) begin
        exp_ovr = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (pu) mq.push_back(push_at[cyc]);
      end
    end else begin
      mq.delete();
    end
    exp_valid = (mq.size() != 0);
    if (exp_valid) exp_data = mq[0];
    baud8 = ((cyc + 1) % 4 == 0);
    rx_if.rx_ack = ((ack_mode == 1) && ($urandom_range(0, 3) == 0)) || (cyc + 1 == ack_edge);
  endtask

  task automatic set_reset(input logic v);
    rst_n = v;
    if (!v) begin
      mq.delete();
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_ferr  = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    rxd = 1'b1;
    repeat (k) step();
  endtask

  // Drive one frame. The line value driven after edge n is seen by the FSM
  // from edge n+3; the start is detected on the first baud8 edge at or after
  // that, and the stop bit is judged 76 strobes (304 clocks) later.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int rst_bit);
    int n, d;
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    n = cyc;
    d = ((n + 6) / 4) * 4;
    if (rst_bit < 0) begin
      if (stop_v) push_at[d + 304] = b;
      else        ferr_at[d + 304] = 1'b1;
      if (ack_next_push) ack_edge = d + 304;
    end
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < 32; k++) begin
        if (j == rst_bit && k == 10) begin
          rxd = 1'b1;
          set_reset(1'b0);
          repeat (3) step();
          set_reset(1'b1);
          return;
        end
        rxd = bits[j];
        step();
      end
    end
    rxd = 1'b1;
  endtask

  task automatic drain();
    ack_mode = 0;
    repeat (MDEPTH + 2) begin
      rx_if.rx_ack = 1'b1;
      step();
    end
    check("drain_valid", {31'd0, rx_if.rx_valid}, 32'd0);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {31'd0, rx_if.rx_valid}, {31'd0, exp_valid});
      if (exp_valid) check("data", {24'd0, rx_if.rx_data}, {24'd0, exp_data});
      check("overrun", {31'd0, rx_if.rx_overrun}, {31'd0, exp_ovr});
      check("frame_err", {31'd0, rx_if.rx_frame_err}, {31'd0, exp_ferr});
      if (rx_if.rx_overrun === 1'b1) ovr_cnt++;
      if (rx_if.rx_frame_err === 1'b1) ferr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ob, fb;
    logic [7:0] rb;
    rst_n = 1'b0;
    rxd = 1'b1;
    baud8 = 1'b0;
    rx_if.rx_ack = 1'b0;
    repeat (4) step();
    set_reset(1'b1);
    step();
    chk_en = 1'b1;
    check("reset_data", {24'd0, rx_if.rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_if.rx_valid}, 32'd0);

    // 1: plain byte then ack
    idle(7);
    send_frame(8'h5A, 1'b1, -1);
    idle(3);
    check("t1_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    check("t1_data", {24'd0, rx_if.rx_data}, 32'h5A);
    rx_if.rx_ack = 1'b1;
    step();
    check("t1_ack_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check("t1_flags", ovr_cnt + ferr_cnt, 32'd0);

    // 2: short low glitch, then a real frame
    rxd = 1'b0;
    repeat (8) step();
    idle(24);
    check("t2_glitch_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    send_frame(8'hC3, 1'b1, -1);
    idle(3);
    check("t2_data", {24'd0, rx_if.rx_data}, 32'hC3);
    check("t2_flags", ovr_cnt + ferr_cnt, 32'd0);
    drain();

    // 3: framing error, long break, then a good byte
    send_frame(8'h41, 1'b0, -1);
    rxd = 1'b0;
    repeat (40 * 32) step();
    idle(12);
    check("t3_break_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    send_frame(8'h42, 1'b1, -1);
    idle(3);
    check("t3_ferr_count", ferr_cnt, 32'd1);
    check("t3_data", {24'd0, rx_if.rx_data}, 32'h42);
    drain();

    // 4: overrun with no ack
    ob = ovr_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
`ifdef FPGA_ROBOTS_RX_FIFO_EN
    send_frame(8'h33, 1'b1, -1);
    send_frame(8'h44, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
`endif
    idle(3);
    check("t4_overrun_count", ovr_cnt - ob, 32'd1);
    check("t4_data", {24'd0, rx_if.rx_data}, 32'h11);
    drain();

    // 5: ack lands on the push cycle of the second byte
    ob = ovr_cnt;
    send_frame(8'h77, 1'b1, -1);
    ack_next_push = 1'b1;
    send_frame(8'h99, 1'b1, -1);
    ack_next_push = 1'b0;
    idle(3);
    check("t5_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    check("t5_data", {24'd0, rx_if.rx_data}, 32'h99);
    check("t5_overrun", ovr_cnt - ob, 32'd0);

    // 6: reset during data bit 4 (stored 8'h99 must also be cleared)
    send_frame(8'hE7, 1'b1, 5);
    idle(16);
    check("t6_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check("t6_data", {24'd0, rx_if.rx_data}, 32'h00);
    send_frame(8'hF0, 1'b1, -1);
    idle(3);
    check("t6_next_data", {24'd0, rx_if.rx_data}, 32'hF0);
    drain();

    // Randomised traffic with random acks, gaps and occasional framing errors.
    fb = ferr_cnt;
    ack_mode = 1;
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(rb, 1'b0, -1);
        rxd = 1'b0;
        repeat ($urandom_range(0, 64)) step();
        idle(12 + $urandom_range(0, 7));
      end else begin
        send_frame(rb, 1'b1, -1);
        idle($urandom_range(0, 15));
      end
    end
    idle(8);
    drain();
    check("rand_ferr_nonneg", {31'd0, ferr_cnt >= fb}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
